// File: rtl/switch_debouncer.sv
// Switch input conditioner: synchronizer, per-bit debounce counter, registered edge strobes.
// Output follows a bit after STABLE_CYCLES consecutive enabled mismatching samples.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  out_q, out_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              changed_q, changed_d;
  logic [WIDTH-1:0]                  synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = switch_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Any agreement clears the count, even with sample_en low; mismatches only count when enabled.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (synced[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (sample_en) begin
        if (cnt_q[i] == CNT_MAX) begin
          out_d[i]  = synced[i];
          cnt_d[i]  = '0;
          rise_d[i] = synced[i];
          fall_d[i] = ~synced[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign switch_out = out_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign changed    = changed_q;

endmodule
